// File: rtl/ready_decoupler.sv
// Two-entry skid buffer that breaks the ready path between upstream and downstream.
// Every output is a flop; OUT drives dout_data, SKID absorbs the beat that arrives during a stall.
module ready_decoupler #(
    parameter int DIN = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           din_valid,
    input  logic [DIN-1:0] din_data,
    output logic           din_ready,
    output logic           dout_valid,
    output logic [DIN-1:0] dout_data,
    input  logic           dout_ready,
    output logic [1:0]     occupancy
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [DIN-1:0] r_out;
    logic [DIN-1:0] r_skid;
    logic [DIN-1:0] w_out_nxt;
    logic [DIN-1:0] w_skid_nxt;
    logic           r_din_ready;
    logic           r_dout_valid;
    logic [1:0]     r_occupancy;
    logic           w_din_ready_nxt;
    logic           w_dout_valid_nxt;
    logic [1:0]     w_occupancy_nxt;
    logic           w_in_hs;
    logic           w_out_hs;

    assign w_in_hs  = din_valid & r_din_ready;
    assign w_out_hs = r_dout_valid & dout_ready;

    // Next-state and storage update decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_out_nxt   = r_out;
        w_skid_nxt  = r_skid;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_hs) begin
                    w_out_nxt   = din_data;
                    w_state_nxt = ST_BUSY;
                end else begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_BUSY: begin
                if (w_in_hs && w_out_hs) begin
                    w_out_nxt   = din_data;
                    w_state_nxt = ST_BUSY;
                end else if (w_in_hs) begin
                    w_skid_nxt  = din_data;
                    w_state_nxt = ST_FULL;
                end else if (w_out_hs) begin
                    w_state_nxt = ST_EMPTY;
                end else begin
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_FULL: begin
                // SKID is only ever read back through OUT, never written here.
                if (w_out_hs) begin
                    w_out_nxt   = r_skid;
                    w_state_nxt = ST_BUSY;
                end else begin
                    w_state_nxt = ST_FULL;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // Decode the flag outputs from the next state so they can be registered.
    always_comb begin
        w_din_ready_nxt  = 1'b1;
        w_dout_valid_nxt = 1'b0;
        w_occupancy_nxt  = 2'd0;
        case (w_state_nxt)
            ST_EMPTY: begin
                w_din_ready_nxt  = 1'b1;
                w_dout_valid_nxt = 1'b0;
                w_occupancy_nxt  = 2'd0;
            end
            ST_BUSY: begin
                w_din_ready_nxt  = 1'b1;
                w_dout_valid_nxt = 1'b1;
                w_occupancy_nxt  = 2'd1;
            end
            ST_FULL: begin
                w_din_ready_nxt  = 1'b0;
                w_dout_valid_nxt = 1'b1;
                w_occupancy_nxt  = 2'd2;
            end
            default: begin
                w_din_ready_nxt  = 1'b1;
                w_dout_valid_nxt = 1'b0;
                w_occupancy_nxt  = 2'd0;
            end
        endcase
    end

    // State, storage and output flops; reset discards any stored beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_EMPTY;
            r_out        <= {DIN{1'b0}};
            r_skid       <= {DIN{1'b0}};
            r_din_ready  <= 1'b1;
            r_dout_valid <= 1'b0;
            r_occupancy  <= 2'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_out        <= w_out_nxt;
            r_skid       <= w_skid_nxt;
            r_din_ready  <= w_din_ready_nxt;
            r_dout_valid <= w_dout_valid_nxt;
            r_occupancy  <= w_occupancy_nxt;
        end
    end

    assign din_ready  = r_din_ready;
    assign dout_valid = r_dout_valid;
    assign dout_data  = r_out;
    assign occupancy  = r_occupancy;

endmodule

// File: tb/tb_ready_decoupler.sv
// Scoreboard bench for ready_decoupler: accepted beats are queued and compared on each output handshake.
module tb_ready_decoupler;

    localparam int DIN = 16;

    logic           clk;
    logic           rst;
    logic           din_valid;
    logic [DIN-1:0] din_data;
    logic           din_ready;
    logic           dout_valid;
    logic [DIN-1:0] dout_data;
    logic           dout_ready;
    logic [1:0]     occupancy;

    int             n_checks;
    int             n_errors;
    int             n_pops;
    logic [DIN-1:0] sb_q[$];
    logic           mon_en;
    logic           hold_prev;
    logic [DIN-1:0] prev_data;

    ready_decoupler #(.DIN(DIN)) dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din_data   (din_data),
        .din_ready  (din_ready),
        .dout_valid (dout_valid),
        .dout_data  (dout_data),
        .dout_ready (dout_ready),
        .occupancy  (occupancy)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: check outputs against the model mid-cycle, probe for
    // combinational paths, apply handshakes to the scoreboard, then advance.
    task automatic step();
        logic [19:0]    snap;
        logic [DIN-1:0] exp;
        @(negedge clk);
        if (mon_en) begin
            chk("occupancy", {30'd0, occupancy}, 32'(sb_q.size()));
            chk("din_ready", {31'd0, din_ready}, (sb_q.size() < 2) ? 32'd1 : 32'd0);
            chk("dout_valid", {31'd0, dout_valid}, (sb_q.size() != 0) ? 32'd1 : 32'd0);
            if (hold_prev) begin
                chk("stall_valid", {31'd0, dout_valid}, 32'd1);
                chk("stall_data", {16'd0, dout_data}, {16'd0, prev_data});
            end
            snap = {din_ready, dout_valid, dout_data, occupancy};
            din_valid  = ~din_valid;
            dout_ready = ~dout_ready;
            din_data   = ~din_data;
            rst        = ~rst;
            #1;
            chk("comb_path", {12'd0, din_ready, dout_valid, dout_data, occupancy}, {12'd0, snap});
            din_valid  = ~din_valid;
            dout_ready = ~dout_ready;
            din_data   = ~din_data;
            rst        = ~rst;
            #1;
            if (rst) begin
                sb_q.delete();
            end else begin
                if (dout_valid && dout_ready) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_beat", {16'd0, dout_data}, 32'hFFFF_FFFF);
                    end else begin
                        exp = sb_q.pop_front();
                        chk("dout_data", {16'd0, dout_data}, {16'd0, exp});
                        n_pops++;
                    end
                end
                if (din_valid && din_ready) sb_q.push_back(din_data);
            end
            hold_prev = !rst && dout_valid && !dout_ready;
            prev_data = dout_data;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pops_before;
        n_checks   = 0;
        n_errors   = 0;
        n_pops     = 0;
        mon_en     = 1'b0;
        hold_prev  = 1'b0;
        prev_data  = '0;
        rst        = 1'b1;
        din_valid  = 1'b0;
        din_data   = 16'h0000;
        dout_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_din_ready", {31'd0, din_ready}, 32'd1);
        chk("rst_dout_valid", {31'd0, dout_valid}, 32'd0);
        chk("rst_dout_data", {16'd0, dout_data}, 32'd0);
        chk("rst_occupancy", {30'd0, occupancy}, 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Single beat with one-cycle latency.
        din_valid  = 1'b1;
        din_data   = 16'h1234;
        dout_ready = 1'b1;
        step();
        din_valid = 1'b0;
        chk("single_valid", {31'd0, dout_valid}, 32'd1);
        chk("single_data", {16'd0, dout_data}, 32'h0000_1234);
        step();
        chk("single_occ", {30'd0, occupancy}, 32'd0);
        step();

        // Back-to-back stream of 0..99.
        pops_before = n_pops;
        for (int i = 0; i < 100; i++) begin
            din_valid = 1'b1;
            din_data  = 16'(i);
            chk("stream_din_ready", {31'd0, din_ready}, 32'd1);
            step();
        end
        din_valid = 1'b0;
        step();
        step();
        chk("stream_count", 32'(n_pops - pops_before), 32'd100);

        // Backpressure: fill both entries, third beat must wait upstream.
        dout_ready = 1'b0;
        din_valid  = 1'b1;
        din_data   = 16'h000A;
        step();
        din_data = 16'h000B;
        step();
        din_data = 16'h000C;
        step();
        step();
        chk("bp_occ", {30'd0, occupancy}, 32'd2);
        chk("bp_din_ready", {31'd0, din_ready}, 32'd0);
        chk("bp_data", {16'd0, dout_data}, 32'h0000_000A);
        dout_ready = 1'b1;
        step();
        chk("bp_second", {16'd0, dout_data}, 32'h0000_000B);
        step();
        din_valid = 1'b0;
        chk("bp_third", {16'd0, dout_data}, 32'h0000_000C);
        step();
        step();

        // Simultaneous in/out handshake while BUSY.
        dout_ready = 1'b0;
        din_valid  = 1'b1;
        din_data   = 16'h0005;
        step();
        din_data   = 16'h0006;
        dout_ready = 1'b1;
        step();
        din_valid = 1'b0;
        chk("simul_data", {16'd0, dout_data}, 32'h0000_0006);
        chk("simul_occ", {30'd0, occupancy}, 32'd1);
        step();

        // Reset while FULL discards both beats.
        dout_ready = 1'b0;
        din_valid  = 1'b1;
        din_data   = 16'h0011;
        step();
        din_data = 16'h0022;
        step();
        din_valid = 1'b0;
        chk("full_occ", {30'd0, occupancy}, 32'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("fullrst_dout_valid", {31'd0, dout_valid}, 32'd0);
        chk("fullrst_din_ready", {31'd0, din_ready}, 32'd1);
        chk("fullrst_occ", {30'd0, occupancy}, 32'd0);
        chk("fullrst_data", {16'd0, dout_data}, 32'd0);
        dout_ready = 1'b1;
        repeat (3) step();
        chk("fullrst_no_stale", {31'd0, dout_valid}, 32'd0);

        // Random traffic.
        for (int i = 0; i < 10000; i++) begin
            din_valid  = 1'($urandom_range(0, 1));
            dout_ready = 1'($urandom_range(0, 1));
            din_data   = 16'($urandom);
            step();
        end
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        for (int i = 0; i < 10 && sb_q.size() != 0; i++) step();
        chk("drain_empty", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
